fpu_arbiter: RTL and testbench
==============================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter FPU_LATENCY, default 2: cycles from operands at fpu inputs to result/flags valid at fpu outputs; legal range 1..8.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1  requester n has an operation pending.
REQ-005 SHALL have ports req0_ready, req1_ready  output  1  grant; the operation transfers at an edge where valid and ready are both high.
REQ-006 SHALL have ports req0_opA, req0_opB, req1_opA, req1_opB  input  16  half-precision operands.
REQ-007 SHALL have ports req0_op, req1_op  input  2  fpu operation code.
REQ-008 SHALL have ports fpu_opA, fpu_opB  output  16, and fpu_op  output  2: registered operands and op driven to the shared fpu.
REQ-009 SHALL have ports fpu_result  input  16, and fpu_underflow, fpu_overflow, fpu_inexact  input  1 each: fpu outputs.
REQ-010 SHALL have ports rsp0_valid, rsp1_valid  output  1  single-cycle result strobe per requester.
REQ-011 SHALL have ports rsp0_result, rsp1_result  output  16, and rsp0_flags, rsp1_flags  output  3 {underflow, overflow, inexact}.
REQ-012 SHALL have port inflight  output  4  number of issued operations whose response has not yet been delivered.

Function
REQ-013 SHALL grant at most one requester per cycle; req_ready is combinational from the req_valid inputs and last_grant; it never depends on operand values.
REQ-014 SHALL grant the only valid requester when exactly one is valid.
REQ-015 SHALL, when both are valid, grant the requester that is not last_grant; last_grant updates only on a transfer.
REQ-016 SHALL register the granted requester's opA/opB/op into fpu_opA/fpu_opB/fpu_op at the transfer edge; in a cycle with no transfer these registers load 16'h0000/16'h0000/2'b00.
REQ-017 SHALL carry a {valid, id} tag through a shift register of depth 1+FPU_LATENCY; a transfer at edge N SHALL assert rsp<id>_valid during the cycle following edge N+FPU_LATENCY+1 (one pulse per transfer).
REQ-018 SHALL drive rsp<id>_result and rsp<id>_flags from the fpu outputs in the rsp_valid cycle; the non-selected requester's rsp_valid SHALL be 0 and its result/flags SHALL be 0.
REQ-019 SHALL sustain one transfer per cycle (full pipelining) with no bubbles; responses return in grant order; there is no response backpressure.
REQ-020 SHALL update inflight as +1 on a transfer and -1 on a rsp_valid; when both occur in the same cycle it SHALL remain unchanged; maximum value is FPU_LATENCY+1.
REQ-021 SHALL not alter a pending request's priority when its valid drops before grant; a requester dropping valid receives no grant.

Reset
REQ-022 SHALL, on reset low, asynchronously clear: req_ready paths qualified to 0, fpu_opA/fpu_opB/fpu_op to 0, all tags invalid, rsp_valid/result/flags to 0, inflight to 0, last_grant to 1 (requester 0 wins the first contention).
REQ-023 SHALL discard in-flight operations on reset mid-operation: no rsp_valid for any transfer made before reset assertion, even after deassertion.
REQ-024 SHALL hold req0_ready and req1_ready at 0 while reset is low.

Configuration
REQ-025 SHALL compile per-requester grant counters when macro FPU_ARBITER_STATS_EN is defined: outputs grant_count0, grant_count1 (16 bits each), +1 per transfer, saturating at 16'hFFFF, cleared by reset.
REQ-026 SHALL, without FPU_ARBITER_STATS_EN, omit those ports and counters entirely; all other behaviour is identical.

Verification
REQ-027 SHALL pass: req0 only, opA=16'h3C00, opB=16'h4000, op=2'b00, FPU_LATENCY=2 -> req0_ready=1 at edge N; fpu_opA=16'h3C00 after N; rsp0_valid in cycle after N+3; rsp1_valid stays 0.
REQ-028 SHALL pass: both valid continuously for 6 cycles after reset -> grants 0,1,0,1,0,1; rsp strobes in the same order; inflight peaks at 3.
REQ-029 SHALL pass: req1 only for 3 transfers, then both valid -> next grant goes to req0.
REQ-030 SHALL pass: transfer at N, reset asserted at edge N+1 for one cycle -> no rsp_valid ever appears for that transfer; inflight=0.
REQ-031 SHALL pass: fpu model returns result=16'h7C00 with overflow=1, inexact=1 for req1 operation -> rsp1_result=16'h7C00, rsp1_flags=3'b011.
REQ-032 SHALL pass with FPU_ARBITER_STATS_EN: 70000 consecutive req0 transfers -> grant_count0=16'hFFFF, grant_count1=0.

Source files
------------

// File: rtl/fpu_arbiter.sv
// Two-requester round-robin front end for a shared pipelined half-precision FPU.
// Optional per-requester grant counters are compiled in when FPU_ARBITER_STATS_EN is defined.
module fpu_arbiter #(
  parameter int unsigned FPU_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [15:0] req0_opA,
  input  logic [15:0] req0_opB,
  input  logic [15:0] req1_opA,
  input  logic [15:0] req1_opB,
  input  logic [1:0]  req0_op,
  input  logic [1:0]  req1_op,
  output logic [15:0] fpu_opA,
  output logic [15:0] fpu_opB,
  output logic [1:0]  fpu_op,
  input  logic [15:0] fpu_result,
  input  logic        fpu_underflow,
  input  logic        fpu_overflow,
  input  logic        fpu_inexact,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [15:0] rsp0_result,
  output logic [15:0] rsp1_result,
  output logic [2:0]  rsp0_flags,
  output logic [2:0]  rsp1_flags,
`ifdef FPU_ARBITER_STATS_EN
  output logic [15:0] grant_count0,
  output logic [15:0] grant_count1,
`endif
  output logic [3:0]  inflight
);

  logic              last_grant_q, last_grant_d;
  logic [15:0]       fpu_opa_q, fpu_opa_d;
  logic [15:0]       fpu_opb_q, fpu_opb_d;
  logic [1:0]        fpu_op_q, fpu_op_d;
  logic [FPU_LATENCY:0] tag_vld_q, tag_vld_d;
  logic [FPU_LATENCY:0] tag_id_q, tag_id_d;
  logic              rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [15:0]       rsp0_result_q, rsp0_result_d, rsp1_result_q, rsp1_result_d;
  logic [2:0]        rsp0_flags_q, rsp0_flags_d, rsp1_flags_q, rsp1_flags_d;
  logic [3:0]        inflight_q, inflight_d;
  logic              xfer0, xfer1, xfer_any, tag_out_vld, tag_out_id;
  logic [2:0]        fpu_flags;

  // Grant: lone requester wins; on contention the one not granted last wins.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (reset) begin
      if (req0_valid && req1_valid) begin
        req0_ready = last_grant_q;
        req1_ready = ~last_grant_q;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign xfer0       = req0_valid & req0_ready;
  assign xfer1       = req1_valid & req1_ready;
  assign xfer_any    = xfer0 | xfer1;
  assign tag_out_vld = tag_vld_q[FPU_LATENCY];
  assign tag_out_id  = tag_id_q[FPU_LATENCY];
  assign fpu_flags   = {fpu_underflow, fpu_overflow, fpu_inexact};

  always_comb begin
    last_grant_d = last_grant_q;
    if (xfer1) begin
      last_grant_d = 1'b1;
    end else if (xfer0) begin
      last_grant_d = 1'b0;
    end

    fpu_opa_d = 16'h0000;
    fpu_opb_d = 16'h0000;
    fpu_op_d  = 2'b00;
    if (xfer0) begin
      fpu_opa_d = req0_opA;
      fpu_opb_d = req0_opB;
      fpu_op_d  = req0_op;
    end else if (xfer1) begin
      fpu_opa_d = req1_opA;
      fpu_opb_d = req1_opB;
      fpu_op_d  = req1_op;
    end

    // Tag index k holds the transfer made k+1 edges ago; the last stage lines up with fpu output.
    tag_vld_d = {tag_vld_q[FPU_LATENCY-1:0], xfer_any};
    tag_id_d  = {tag_id_q[FPU_LATENCY-1:0], xfer1};

    rsp0_valid_d  = tag_out_vld & ~tag_out_id;
    rsp1_valid_d  = tag_out_vld & tag_out_id;
    rsp0_result_d = rsp0_valid_d ? fpu_result : 16'h0000;
    rsp1_result_d = rsp1_valid_d ? fpu_result : 16'h0000;
    rsp0_flags_d  = rsp0_valid_d ? fpu_flags : 3'b000;
    rsp1_flags_d  = rsp1_valid_d ? fpu_flags : 3'b000;

    inflight_d = inflight_q + {3'b000, xfer_any} - {3'b000, tag_out_vld};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q  <= 1'b1;
      fpu_opa_q     <= 16'h0000;
      fpu_opb_q     <= 16'h0000;
      fpu_op_q      <= 2'b00;
      tag_vld_q     <= '0;
      tag_id_q      <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= 16'h0000;
      rsp1_result_q <= 16'h0000;
      rsp0_flags_q  <= 3'b000;
      rsp1_flags_q  <= 3'b000;
      inflight_q    <= 4'd0;
    end else begin
      last_grant_q  <= last_grant_d;
      fpu_opa_q     <= fpu_opa_d;
      fpu_opb_q     <= fpu_opb_d;
      fpu_op_q      <= fpu_op_d;
      tag_vld_q     <= tag_vld_d;
      tag_id_q      <= tag_id_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
      rsp0_flags_q  <= rsp0_flags_d;
      rsp1_flags_q  <= rsp1_flags_d;
      inflight_q    <= inflight_d;
    end
  end

  assign fpu_opA     = fpu_opa_q;
  assign fpu_opB     = fpu_opb_q;
  assign fpu_op      = fpu_op_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp0_flags  = rsp0_flags_q;
  assign rsp1_flags  = rsp1_flags_q;
  assign inflight    = inflight_q;

`ifdef FPU_ARBITER_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (xfer0 && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
    if (xfer1 && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0_q <= 16'h0000;
      cnt1_q <= 16'h0000;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_count0 = cnt0_q;
  assign grant_count1 = cnt1_q;
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a small latency-2 fpu model; grant counters are
// exercised only when FPU_ARBITER_STATS_EN is defined.
module tb_fpu_arbiter;
  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_opA = '0, req0_opB = '0, req1_opA = '0, req1_opB = '0;
  logic [1:0]  req0_op = '0, req1_op = '0;
  logic [15:0] fpu_opA, fpu_opB, fpu_result;
  logic [1:0]  fpu_op;
  logic        fpu_underflow, fpu_overflow, fpu_inexact;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_result, rsp1_result;
  logic [2:0]  rsp0_flags, rsp1_flags;
  logic [3:0]  inflight;
`ifdef FPU_ARBITER_STATS_EN
  logic [15:0] grant_count0, grant_count1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_arbiter #(.FPU_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_opA(req0_opA), .req0_opB(req0_opB), .req1_opA(req1_opA), .req1_opB(req1_opB),
    .req0_op(req0_op), .req1_op(req1_op),
    .fpu_opA(fpu_opA), .fpu_opB(fpu_opB), .fpu_op(fpu_op),
    .fpu_result(fpu_result), .fpu_underflow(fpu_underflow),
    .fpu_overflow(fpu_overflow), .fpu_inexact(fpu_inexact),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_result(rsp0_result), .rsp1_result(rsp1_result),
    .rsp0_flags(rsp0_flags), .rsp1_flags(rsp1_flags),
`ifdef FPU_ARBITER_STATS_EN
    .grant_count0(grant_count0), .grant_count1(grant_count1),
`endif
    .inflight(inflight)
  );

  // Fpu model: {underflow, overflow, inexact, result}, LAT register stages.
  function automatic logic [18:0] fpu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] op);
    case (op)
      2'b00:   fpu_f = {3'b000, a + b};
      2'b01:   fpu_f = {3'b100, a - b};
      2'b10:   fpu_f = {3'b001, a ^ b};
      default: fpu_f = {3'b011, 16'h7C00};
    endcase
  endfunction

  logic [18:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= fpu_f(fpu_opA, fpu_opB, fpu_op);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {fpu_underflow, fpu_overflow, fpu_inexact, fpu_result} = pipe[LAT-1];

  task automatic do_reset();
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({fpu_opA, fpu_opB, fpu_op} !== 34'd0) begin
      errors++; $display("FAIL reset_fpu_ops: got %h/%h/%b want 0", fpu_opA, fpu_opB, fpu_op);
    end
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp0_result, rsp1_result, rsp0_flags, rsp1_flags} !== 40'd0)
    begin
      errors++; $display("FAIL reset_rsp: got v=%b%b r0=%h r1=%h", rsp0_valid, rsp1_valid,
                         rsp0_result, rsp1_result);
    end
    checks++;
    if (inflight !== 4'd0) begin
      errors++; $display("FAIL reset_inflight: got %0d want 0", inflight);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1'b1; req0_opA = 16'h3C00; req0_opB = 16'h4000; req0_op = 2'b00;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL single_grant: got %b want 10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if ({fpu_opA, fpu_opB, fpu_op} !== {16'h3C00, 16'h4000, 2'b00}) begin
      errors++; $display("FAIL single_fpu_ops: got %h/%h/%b want 3c00/4000/00",
                         fpu_opA, fpu_opB, fpu_op);
    end
    checks++;
    if (inflight !== 4'd1) begin
      errors++; $display("FAIL single_inflight: got %0d want 1", inflight);
    end
    @(negedge clk);
    checks++;
    if (fpu_opA !== 16'h0000) begin
      errors++; $display("FAIL single_idle_opA: got %h want 0000", fpu_opA);
    end
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL single_early_rsp: got %b want 0", rsp0_valid);
    end
    @(negedge clk);
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp0_result, rsp0_flags} !== {2'b10, 16'h7C00, 3'b000}) begin
      errors++; $display("FAIL single_rsp: got v=%b%b r=%h f=%b want v=10 r=7c00 f=000",
                         rsp0_valid, rsp1_valid, rsp0_result, rsp0_flags);
    end
    checks++;
    if (inflight !== 4'd0) begin
      errors++; $display("FAIL single_drain: got %0d want 0", inflight);
    end
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL single_pulse: got %b want 0", rsp0_valid);
    end
  endtask

  task automatic test_back_to_back();
    int j, dn, exp_inf, peak;
    logic exp0;
    do_reset();
    req0_opA = 16'h0001; req0_opB = 16'h0002; req0_op = 2'b00;
    req1_opA = 16'h0010; req1_opB = 16'h0004; req1_op = 2'b01;
    peak = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req0_valid = (k < 6);
      req1_valid = (k < 6);
      #1;
      exp0 = ((k % 2) == 0);
      checks++;
      if (k < 6 && {req0_ready, req1_ready} !== {exp0, ~exp0}) begin
        errors++; $display("FAIL b2b_grant k=%0d: got %b want %b", k,
                           {req0_ready, req1_ready}, {exp0, ~exp0});
      end else if (k >= 6 && {req0_ready, req1_ready} !== 2'b00) begin
        errors++; $display("FAIL b2b_idle k=%0d: got %b want 00", k, {req0_ready, req1_ready});
      end
      j = k - 4;
      checks++;
      if (j >= 0 && j < 6 && (j % 2) == 0) begin
        if ({rsp0_valid, rsp1_valid, rsp0_result, rsp1_result} !== {2'b10, 16'h0003, 16'h0})
        begin
          errors++; $display("FAIL b2b_rsp0 k=%0d: got v=%b%b r0=%h r1=%h want 10/0003/0000",
                             k, rsp0_valid, rsp1_valid, rsp0_result, rsp1_result);
        end
      end else if (j >= 0 && j < 6) begin
        if ({rsp0_valid, rsp1_valid, rsp1_result, rsp1_flags} !== {2'b01, 16'h000C, 3'b100})
        begin
          errors++; $display("FAIL b2b_rsp1 k=%0d: got v=%b%b r1=%h f1=%b want 01/000c/100",
                             k, rsp0_valid, rsp1_valid, rsp1_result, rsp1_flags);
        end
      end else if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
        errors++; $display("FAIL b2b_norsp k=%0d: got %b want 00", k, {rsp0_valid, rsp1_valid});
      end
      dn = (k - 3 < 0) ? 0 : ((k - 3 > 6) ? 6 : k - 3);
      exp_inf = ((k < 6) ? k : 6) - dn;
      checks++;
      if (inflight !== 4'(exp_inf)) begin
        errors++; $display("FAIL b2b_inflight k=%0d: got %0d want %0d", k, inflight, exp_inf);
      end
      if (int'(inflight) > peak) peak = int'(inflight);
    end
    checks++;
    if (peak !== 3) begin
      errors++; $display("FAIL b2b_peak: got %0d want 3", peak);
    end
  endtask

  task automatic test_priority();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
        errors++; $display("FAIL prio_req1 k=%0d: got %b want 01", k, {req0_ready, req1_ready});
      end
    end
    @(negedge clk);
    req0_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL prio_contend: got %b want 10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req0_valid = 1'b1; req0_opA = 16'h0001; req0_opB = 16'h0001; req0_op = 2'b00;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL mid_ready: got %b want 00", {req0_ready, req1_ready});
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({rsp0_valid, rsp1_valid, inflight} !== 6'd0) begin
        errors++; $display("FAIL mid_discard k=%0d: got v=%b%b inflight=%0d want 00/0", k,
                           rsp0_valid, rsp1_valid, inflight);
      end
    end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    req1_valid = 1'b1; req1_opA = 16'h1234; req1_opB = 16'h5678; req1_op = 2'b11;
    @(negedge clk);
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (rsp1_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_early: got %b want 0", rsp1_valid);
    end
    @(negedge clk);
    checks++;
    if ({rsp1_valid, rsp1_result, rsp1_flags} !== {1'b1, 16'h7C00, 3'b011}) begin
      errors++; $display("FAIL ovf_rsp1: got v=%b r=%h f=%b want 1/7c00/011",
                         rsp1_valid, rsp1_result, rsp1_flags);
    end
    checks++;
    if ({rsp0_valid, rsp0_result, rsp0_flags} !== 20'd0) begin
      errors++; $display("FAIL ovf_rsp0_quiet: got v=%b r=%h f=%b want 0", rsp0_valid,
                         rsp0_result, rsp0_flags);
    end
  endtask

`ifdef FPU_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 2'b00;
    repeat (70000) @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({grant_count0, grant_count1} !== {16'hFFFF, 16'h0000}) begin
      errors++; $display("FAIL stats_sat: got %h/%h want ffff/0000", grant_count0, grant_count1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_priority();
    test_reset_mid();
    test_overflow();
`ifdef FPU_ARBITER_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
